sdram_wbuf: RTL
===============

// Module: sdram_wbuf
// PURPOSE
// - Posted-write buffer between memif_sdram's SDRAM_* request port and the SDRAM controller.
// - Writes from the CPU memory interface complete in one cycle into a FIFO; the FIFO drains to the controller in background.
// - Reads pass through in order with respect to buffered writes; returned data is held stable for the requester.
// PARAMETERS
// - DEPTH  4  write FIFO entries; power of 2, range 2..16
// PORTS
// - SDRAM_CLK   in   1   sole clock; upstream and downstream ports are both in this domain
// - SDRAM_RST   in   1   synchronous reset, active-high
// - UP_WADDR    in   25  write byte address
// - UP_DIN      in   32  write data
// - UP_BE       in   4   write byte enables
// - UP_WE       in   1   write strobe; accepted when UP_WE_RDY=1
// - UP_WE_RDY   out  1   FIFO not full
// - UP_RADDR    in   25  read byte address
// - UP_RD       in   1   read strobe; accepted when UP_RD_RDY=1
// - UP_RD_RDY   out  1   no read outstanding; UP_DOUT valid on each rise
// - UP_DOUT     out  32  read data, held until the next read completes
// - DN_WADDR / DN_DIN / DN_BE  out  25/32/4  head FIFO entry
// - DN_WE       out  1   one-cycle write strobe to the controller
// - DN_WE_RDY   in   1   controller write idle
// - DN_RADDR    out  25  registered read address
// - DN_RD       out  1   one-cycle read strobe to the controller
// - DN_RD_RDY   in   1   controller read idle; DN_DOUT valid on each rise
// - DN_DOUT     in   32  controller read data
// BEHAVIOUR
// - Reset values: UP_WE_RDY=1, UP_RD_RDY=1, UP_DOUT=0, DN_WE=0, DN_RD=0. FIFO is emptied and the FSM returns to IDLE.
// - Reset mid-operation abandons any in-flight controller access. The controller shares SDRAM_RST.
// - Write accept: on UP_WE & UP_WE_RDY, push {UP_WADDR, UP_DIN, UP_BE}. UP_WE_RDY is combinational ~full.
//   - UP_WE while full is ignored; the requester must hold it off.
// - Read accept: on UP_RD & UP_RD_RDY, latch UP_RADDR into a pending-read register. UP_RD_RDY goes to 0 the next cycle.
// - Simultaneous UP_WE and UP_RD: both are accepted; the write is ordered before the read.
// - FSM states and transitions:
//   - IDLE -> RD_ISSUE when a read is pending and allowed (see CONFIGURATION).
//   - IDLE -> WR_ISSUE when the FIFO is non-empty, DN_WE_RDY=1 and no allowed read is pending. An allowed read takes priority over a drain.
//   - WR_ISSUE: DN_WE=1 for exactly 1 cycle -> WR_GAP.
//   - WR_GAP: 1 cycle; DN_WE_RDY is ignored -> WR_WAIT.
//   - WR_WAIT: on DN_WE_RDY=1, pop the FIFO -> IDLE.
//   - RD_ISSUE: DN_RD=1 for 1 cycle with DN_RADDR -> RD_GAP (1 cycle) -> RD_WAIT.
//   - RD_WAIT: on DN_RD_RDY=1, UP_DOUT<=DN_DOUT and UP_RD_RDY<=1 on the same edge -> IDLE.
// - DN_WADDR/DN_DIN/DN_BE always present the head entry. They stay stable from WR_ISSUE until the pop.
// - FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = MSBs differ, low bits equal. A push and a pop in the same cycle are both honoured, and the count is unchanged.
// - Minimum read latency with an empty FIFO and an idle controller: UP_RD to UP_RD_RDY rise = 4 cycles + controller time.
// - Writes reach the controller strictly in acceptance order. No coalescing or merging of entries.
// CONFIGURATION
// - Macro SDRAM_WBUF_RAW_CHECK_EN controls when a pending read may be issued.
//   - Undefined: a pending read is allowed only when the FIFO is empty, so the FIFO always drains before a read.
//   - Defined: a pending read is allowed when no valid FIFO entry has WADDR[24:2] == pending RADDR[24:2].
//     - An entry pushed in the same cycle counts as valid.
//     - On a match, the FIFO drains until no match remains, then the read issues.
// TESTING
// - Reset: assert SDRAM_RST for 3 cycles with UP_WE=1 -> no push; all outputs at their reset values; FIFO empty afterwards.
// - Fill: DEPTH=4, controller stalled (DN_WE_RDY=0), 5 writes -> UP_WE_RDY=0 after 4 writes; the 5th is dropped. Release the stall -> 4 DN_WE pulses in order, data 0x11111111..0x44444444.
// - Read ordering: write 0x0100004=0xCAFEBABE (BE=4'b1111), then read 0x0100004 on the next cycle -> DN_WE precedes DN_RD; UP_DOUT=0xCAFEBABE when UP_RD_RDY rises.
// - RAW check (macro defined): FIFO holds writes to 0x0800000 and 0x0800010; read 0x0100000 -> DN_RD issues before either write drains. Read 0x0800010 -> both writes drain first.
// - Same-cycle push/pop: FIFO at 3 entries, push coincides with a pop -> count stays 3; UP_WE_RDY stays 1.
// - Reset mid-read: SDRAM_RST in RD_WAIT -> UP_RD_RDY=1, UP_DOUT=0; no stale DN_RD after reset.

Source files
------------

// File: rtl/sdram_wbuf.sv
// sdram_wbuf: posted-write FIFO in front of the SDRAM controller with in-order read pass-through; define SDRAM_WBUF_RAW_CHECK_EN to let reads bypass writes to other words
module sdram_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        SDRAM_CLK,
  input  logic        SDRAM_RST,
  input  logic [24:0] UP_WADDR,
  input  logic [31:0] UP_DIN,
  input  logic [3:0]  UP_BE,
  input  logic        UP_WE,
  output logic        UP_WE_RDY,
  input  logic [24:0] UP_RADDR,
  input  logic        UP_RD,
  output logic        UP_RD_RDY,
  output logic [31:0] UP_DOUT,
  output logic [24:0] DN_WADDR,
  output logic [31:0] DN_DIN,
  output logic [3:0]  DN_BE,
  output logic        DN_WE,
  input  logic        DN_WE_RDY,
  output logic [24:0] DN_RADDR,
  output logic        DN_RD,
  input  logic        DN_RD_RDY,
  input  logic [31:0] DN_DOUT
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_GAP, WR_WAIT, RD_ISSUE, RD_GAP, RD_WAIT} state_t;
  state_t r_state;
  logic [24:0] r_addr [DEPTH];
  logic [31:0] r_din [DEPTH];
  logic [3:0] r_be [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [24:0] r_raddr;
  logic [31:0] r_dout;
  logic r_rd_pend, r_rd_rdy, r_dn_we, r_dn_rd;
  logic w_full, w_empty, w_push, w_rd_ok;
  assign w_empty = r_wptr == r_rptr;
  assign w_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push = UP_WE && !w_full;
  assign UP_WE_RDY = !w_full;
  assign UP_RD_RDY = r_rd_rdy;
  assign UP_DOUT = r_dout;
  assign DN_WADDR = r_addr[r_rptr[AW-1:0]];
  assign DN_DIN = r_din[r_rptr[AW-1:0]];
  assign DN_BE = r_be[r_rptr[AW-1:0]];
  assign DN_WE = r_dn_we;
  assign DN_RADDR = r_raddr;
  assign DN_RD = r_dn_rd;
`ifdef SDRAM_WBUF_RAW_CHECK_EN
  logic [AW:0] w_cnt;
  logic w_hit;
  assign w_cnt = r_wptr - r_rptr;
  // A pending read waits while any live entry, including one pushed this cycle, targets its word
  always_comb begin
    w_hit = w_push && UP_WADDR[24:2] == r_raddr[24:2];
    for (int i = 0; i < DEPTH; i++)
      w_hit = w_hit | (({1'b0, AW'(i) - r_rptr[AW-1:0]} < w_cnt) && r_addr[i][24:2] == r_raddr[24:2]);
  end
  assign w_rd_ok = r_rd_pend && !w_hit;
`else
  assign w_rd_ok = r_rd_pend && w_empty;
`endif
  // Push accepted writes at the FIFO tail
  always_ff @(posedge SDRAM_CLK) begin
    if (SDRAM_RST) r_wptr <= '0;
    else if (w_push) begin
      r_addr[r_wptr[AW-1:0]] <= UP_WADDR;
      r_din[r_wptr[AW-1:0]] <= UP_DIN;
      r_be[r_wptr[AW-1:0]] <= UP_BE;
      r_wptr <= r_wptr + (AW+1)'(1);
    end
  end
  // Accept reads, drain the FIFO head, issue reads and return their data
  always_ff @(posedge SDRAM_CLK) begin
    if (SDRAM_RST) begin
      r_state <= IDLE;
      r_rptr <= '0;
      r_raddr <= '0;
      r_dout <= '0;
      r_rd_pend <= 1'b0;
      r_rd_rdy <= 1'b1;
      r_dn_we <= 1'b0;
      r_dn_rd <= 1'b0;
    end else begin
      r_dn_we <= 1'b0;
      r_dn_rd <= 1'b0;
      if (UP_RD && r_rd_rdy) begin
        r_raddr <= UP_RADDR;
        r_rd_pend <= 1'b1;
        r_rd_rdy <= 1'b0;
      end
      case (r_state)
        IDLE:
          if (w_rd_ok) begin
            r_state <= RD_ISSUE;
            r_dn_rd <= 1'b1;
            r_rd_pend <= 1'b0;
          end else if (!w_empty && DN_WE_RDY) begin
            r_state <= WR_ISSUE;
            r_dn_we <= 1'b1;
          end
        WR_ISSUE: r_state <= WR_GAP;
        WR_GAP: r_state <= WR_WAIT;
        WR_WAIT:
          if (DN_WE_RDY) begin
            r_rptr <= r_rptr + (AW+1)'(1);
            r_state <= IDLE;
          end
        RD_ISSUE: r_state <= RD_GAP;
        RD_GAP: r_state <= RD_WAIT;
        RD_WAIT:
          if (DN_RD_RDY) begin
            r_dout <= DN_DOUT;
            r_rd_rdy <= 1'b1;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
